sram_mem_ctrl: RTL
==================

SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 SHALL have parameter READ_LAT, default 2: read_enable strobe cycles per read.
REQ-002 SHALL have parameter WRITE_LAT, default 2: write_enable strobe cycles per write.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port req_valid, input, 1: request present.
REQ-006 SHALL have port req_ready, output, 1: request accepted when req_valid&&req_ready.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 9: byte address (128 words x 4 bytes).
REQ-009 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned, input, 1: zero-extend load when 1, else sign-extend.
REQ-011 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1: response present.
REQ-013 SHALL have port resp_ready, input, 1: response consumed when resp_valid&&resp_ready.
REQ-014 SHALL have port resp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1: misaligned or illegal-size request.
REQ-016 SHALL have memory-side ports addr_sel (out, 7), byte_sel (out, 4), read_enable (out, 1), write_enable (out, 1), datain (out, 32) and dataout (in, 32), all with SRAM semantics.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL, on accept (cycle 0), latch all req_* fields; go to RESP if misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11, else READ if !req_write, else WRITE.
REQ-019 SHALL drive addr_sel=addr[8:2] registered, from cycle 1 through the end of READ/WRITE.
REQ-020 SHALL set byte_sel: byte 1<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111.
REQ-021 SHALL set datain: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-022 SHALL, in READ, assert read_enable in cycles 1..READ_LAT, deassert it in cycle READ_LAT+1, and capture dataout at the end of cycle READ_LAT+1.
REQ-023 SHALL extract loaded data little-endian: byte dataout[8*addr[1:0]+:8], half dataout[16*addr[1]+:16], then extend to 32 bits per req_unsigned.
REQ-024 SHALL, in WRITE, assert write_enable in cycles 1..WRITE_LAT, then go to RESP.
REQ-025 SHALL never assert read_enable and write_enable together.
REQ-026 SHALL, when neither strobe is asserted, drive byte_sel=0 and datain=0.
REQ-027 SHALL assert resp_valid in cycle READ_LAT+2 (load), WRITE_LAT+1 (store) or 1 (error).
REQ-028 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1.
REQ-029 SHALL return to IDLE on the edge ending the handshake cycle (req_ready=1 next cycle); back-to-back requests therefore carry at least one IDLE cycle.
REQ-030 SHALL assert resp_err only with resp_valid, with resp_rdata=0 and no strobe issued.
REQ-031 SHALL count strobe cycles in an internal counter sized for max(READ_LAT,WRITE_LAT)+1 without wrap.

Reset
REQ-032 SHALL, on any edge with reset=0, enter IDLE and set req_ready=1 (first non-reset cycle); resp_valid=0, resp_rdata=0, resp_err=0, read_enable=0, write_enable=0, addr_sel=0, byte_sel=0, datain=0.
REQ-033 SHALL, on reset mid-operation, drop strobes at that edge and discard the in-flight request and response.

Verification
REQ-034 SHALL pass: store word addr 0x010 data 0xDEADBEEF -> write_enable cycles 1-2, addr_sel=4, byte_sel=1111; resp_valid cycle 3, resp_err=0.
REQ-035 SHALL pass: then signed byte load addr 0x013 -> read_enable cycles 1-2, byte_sel=1000; resp_valid cycle 4, resp_rdata=0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-036 SHALL pass: half store addr 0x016 wdata 0x0000A55A -> datain=0xA55AA55A, byte_sel=1100; unsigned half load 0x016 -> 0x0000A55A.
REQ-037 SHALL pass: word load addr 0x012 -> no strobes, resp_valid cycle 1, resp_err=1, resp_rdata=0.
REQ-038 SHALL pass: resp_ready held 0 for 5 cycles -> response stable, req_ready=0; a request offered meanwhile is accepted only after the handshake.
REQ-039 SHALL pass: reset=0 in cycle 1 of a write -> write_enable=0 next cycle, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: single-outstanding load/store front end for a 128 x 32-bit
// byte-addressable SRAM. Accepts one request at a time, strobes the SRAM for a
// fixed number of cycles, aligns/extends load data and returns one response.
// Ports:
//   clk, reset (sync, active low)
//   req_valid/req_ready/req_write/req_addr/req_size/req_unsigned/req_wdata
//   resp_valid/resp_ready/resp_rdata/resp_err
//   SRAM side: addr_sel, byte_sel, read_enable, write_enable, datain, dataout
module sram_mem_ctrl #(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [8:0]  req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [6:0]  addr_sel,
  output logic [3:0]  byte_sel,
  output logic        read_enable,
  output logic        write_enable,
  output logic [31:0] datain,
  input  logic [31:0] dataout
);
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 2);
  localparam logic [CNT_W-1:0] RD_LAT_C  = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] WR_LAST_C = CNT_W'(WRITE_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [8:0]        addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [6:0]        addr_sel_q, addr_sel_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              bad_req;
  logic              rd_en, wr_en;
  logic [31:0]       ld_ext;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;

  assign bad_req = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Strobes are decoded from registered state, so a reset edge drops them
  // in the very next cycle. The counter stays below the latency while strobing.
  assign rd_en = (state_q == READ)  && (cnt_q < RD_LAT_C);
  assign wr_en = (state_q == WRITE) && (cnt_q <= WR_LAST_C);

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign addr_sel     = addr_sel_q;
  assign read_enable  = rd_en;
  assign write_enable = wr_en;

  always_comb begin
    byte_sel = 4'b0000;
    datain   = 32'h0;
    if (rd_en || wr_en) begin
      unique case (size_q)
        2'b00:   begin
                   byte_sel = 4'b0001 << addr_q[1:0];
                   datain   = {4{wdata_q[7:0]}};
                 end
        2'b01:   begin
                   byte_sel = addr_q[1] ? 4'b1100 : 4'b0011;
                   datain   = {2{wdata_q[15:0]}};
                 end
        default: begin
                   byte_sel = 4'b1111;
                   datain   = wdata_q;
                 end
      endcase
    end
  end

  // Little-endian lane select, then sign/zero extension.
  always_comb begin
    ld_b   = dataout[{addr_q[1:0], 3'b000} +: 8];
    ld_h   = dataout[{addr_q[1], 4'b0000} +: 16];
    ld_ext = dataout;
    unique case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ld_ext = dataout;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    addr_sel_d = addr_sel_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        size_d  = req_size;
        uns_d   = req_unsigned;
        wdata_d = req_wdata;
        cnt_d   = '0;
        rdata_d = 32'h0;
        err_d   = 1'b0;
        if (bad_req) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          addr_sel_d = req_addr[8:2];
          state_d    = req_write ? WRITE : READ;
        end
      end
      READ: begin
        cnt_d = cnt_q + 1'b1;
        // Last cycle has strobe low; SRAM output is valid now.
        if (cnt_q == RD_LAT_C) begin
          rdata_d    = ld_ext;
          addr_sel_d = 7'h0;
          cnt_d      = '0;
          state_d    = RESP;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WR_LAST_C) begin
          addr_sel_d = 7'h0;
          cnt_d      = '0;
          state_d    = RESP;
        end
      end
      RESP: if (resp_ready) begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= 9'h0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= 32'h0;
      addr_sel_q <= 7'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      addr_sel_q <= addr_sel_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end
endmodule
